// File: rtl/gp_dma_wr_eng.sv
// Destination-side DMA drain engine: pops FIFO bytes, issues single-beat 32-bit writes.
// Optional GP_DMA_WR_ENG_STATS_EN adds the wr_beats granted-beat counter.
module gp_dma_wr_eng #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              big_endian,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    input  logic [4:0]        fifo_occ,
    input  logic [31:0]       fifo_rd_data,
    output logic              fifo_rd_en,
    output logic [1:0]        fifo_rd_baddress,
    output logic [2:0]        fifo_rd_xcnt,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_be
`ifdef GP_DMA_WR_ENG_STATS_EN
    ,
    output logic [15:0]       wr_beats
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, REQ, DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic [2:0]        room;
    logic [2:0]        xcnt;
    logic [3:0]        le_be;
    logic [3:0]        be_n;
    logic              pop;
    logic              adv;
    logic              accept;

    // Beat size: bytes to the next word boundary, clipped by what is left.
    assign room  = 3'd4 - {1'b0, cur_addr[1:0]};
    assign xcnt  = (remaining < {{(LEN_W-3){1'b0}}, room}) ? remaining[2:0] : room;
    assign le_be = (4'b1111 >> (3'd4 - xcnt)) << cur_addr[1:0];
    assign be_n  = big_endian ? {le_be[0], le_be[1], le_be[2], le_be[3]} : le_be;

    assign accept           = (state == IDLE) && start;
    assign busy             = (state != IDLE);
    assign done             = (state == DONE);
    assign fifo_rd_en       = pop;
    assign fifo_rd_baddress = cur_addr[1:0];
    assign fifo_rd_xcnt     = xcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        adv     = 1'b0;
        bus_req = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = (len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (fifo_occ >= {2'b00, xcnt}) begin
                    pop     = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                // abort wins over a same-cycle grant, so the request is withdrawn
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    bus_req = 1'b1;
                    if (bus_gnt) begin
                        adv     = 1'b1;
                        state_n = (remaining == {{(LEN_W-3){1'b0}}, xcnt}) ? DONE : FETCH;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr  <= '0;
            remaining <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
        end else begin
            if (accept) begin
                cur_addr  <= dst_addr;
                remaining <= len;
            end else if (adv) begin
                cur_addr  <= cur_addr + ADDR_W'(xcnt);
                remaining <= remaining - LEN_W'(xcnt);
            end
            if (pop) begin
                bus_addr  <= {cur_addr[ADDR_W-1:2], 2'b00};
                bus_wdata <= fifo_rd_data;
                bus_be    <= be_n;
            end
        end
    end

`ifdef GP_DMA_WR_ENG_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_beats <= '0;
        end else if (accept) begin
            wr_beats <= '0;
        end else if (adv && (wr_beats != 16'hFFFF)) begin
            wr_beats <= wr_beats + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gp_dma_wr_eng.sv
// Bench for gp_dma_wr_eng: byte-queue FIFO model, random grants/starvation,
// expected beats derived from address/length arithmetic.
module tb_gp_dma_wr_eng;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len = '0;
    logic        big_endian = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic [4:0]  fifo_occ = '0;
    logic [31:0] fifo_rd_data = '0;
    logic        fifo_rd_en;
    logic [1:0]  fifo_rd_baddress;
    logic [2:0]  fifo_rd_xcnt;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
`ifdef GP_DMA_WR_ENG_STATS_EN
    logic [15:0] wr_beats;
`endif

    gp_dma_wr_eng #(.ADDR_W(32), .LEN_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .dst_addr         (dst_addr),
        .len              (len),
        .big_endian       (big_endian),
        .abort            (abort),
        .busy             (busy),
        .done             (done),
        .fifo_occ         (fifo_occ),
        .fifo_rd_data     (fifo_rd_data),
        .fifo_rd_en       (fifo_rd_en),
        .fifo_rd_baddress (fifo_rd_baddress),
        .fifo_rd_xcnt     (fifo_rd_xcnt),
        .bus_req          (bus_req),
        .bus_gnt          (bus_gnt),
        .bus_addr         (bus_addr),
        .bus_wdata        (bus_wdata),
        .bus_be           (bus_be)
`ifdef GP_DMA_WR_ENG_STATS_EN
        ,
        .wr_beats         (wr_beats)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } beat_t;

    beat_t       obs[$];
    logic [7:0]  fq[$];
    logic [7:0]  eb[$];
    logic [31:0] ex_addr[$];
    logic [3:0]  ex_be[$];
    int          ex_x[$];

    int total = 0;
    int bad = 0;
    int pops = 0;
    int grants = 0;
    int dones = 0;
    int cyc = 0;
    int last_gnt_cyc = 0;
    int last_done_cyc = 0;
    int gnt_mode = 1;
    int occ_cap = -1;
    int thr = 0;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Bench-side FIFO: presents the next bytes rotated into lanes, pops on fifo_rd_en.
    task automatic drive();
        int n;
        int b;
        int x;
        int lane;
        logic [31:0] d;
        case (gnt_mode)
            0: bus_gnt = 1'b0;
            1: bus_gnt = 1'b1;
            default: bus_gnt = ($urandom_range(0, 1) == 1);
        endcase
        n = (fq.size() > 31) ? 31 : fq.size();
        if (occ_cap >= 0 && n > occ_cap) n = occ_cap;
        if (thr != 0 && $urandom_range(0, 2) == 0) n = 0;
        fifo_occ = 5'(n);
        d = '0;
        b = int'(fifo_rd_baddress);
        x = int'(fifo_rd_xcnt);
        for (int k = 0; k < x && k < fq.size(); k++) begin
            lane = big_endian ? (3 - b - k) : (b + k);
            if (lane >= 0 && lane <= 3) d[lane*8 +: 8] = fq[k];
        end
        fifo_rd_data = d;
    endtask

    always begin
        logic pop_s;
        int   px;
        beat_t bt;
        @(negedge clk);
        cyc++;
        pop_s = fifo_rd_en;
        px    = int'(fifo_rd_xcnt);
        if (fifo_rd_en) pops++;
        if (bus_req && bus_gnt && !abort) begin
            bt.addr = bus_addr;
            bt.be   = bus_be;
            bt.data = bus_wdata;
            obs.push_back(bt);
            grants++;
            last_gnt_cyc = cyc;
        end
        if (done) begin
            dones++;
            last_done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        if (pop_s) begin
            for (int k = 0; k < px; k++) begin
                if (fq.size() > 0) void'(fq.pop_front());
            end
        end
        drive();
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    int d0;

    task automatic launch(input logic [31:0] a, input int l, input logic be);
        logic [31:0] ca;
        int rem;
        int b;
        int x;
        logic [3:0] m;
        logic [7:0] v;
        ex_addr.delete();
        ex_be.delete();
        ex_x.delete();
        eb.delete();
        ca  = a;
        rem = l;
        while (rem > 0) begin
            b = int'(ca[1:0]);
            x = (rem < 4 - b) ? rem : 4 - b;
            m = '0;
            for (int k = 0; k < x; k++) begin
                if (be) m[3-b-k] = 1'b1;
                else    m[b+k]   = 1'b1;
            end
            ex_addr.push_back({ca[31:2], 2'b00});
            ex_be.push_back(m);
            ex_x.push_back(x);
            ca  = ca + 32'(x);
            rem = rem - x;
        end
        for (int i = 0; i < l; i++) begin
            v = 8'($urandom);
            eb.push_back(v);
            fq.push_back(v);
        end
        obs.delete();
        d0         = dones;
        dst_addr   = a;
        len        = 16'(l);
        big_endian = be;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic finish_xfer(input string tag, input int budget);
        int bi;
        logic [31:0] ed;
        logic [31:0] mk;
        int lane;
        for (int i = 0; i < budget && dones == d0; i++) step();
        chk({tag, "_done_cnt"}, 64'(dones - d0), 64'd1);
        chk({tag, "_done_lat"}, 64'(last_done_cyc - last_gnt_cyc), 64'd1);
        chk({tag, "_nbeats"}, 64'(obs.size()), 64'(ex_addr.size()));
        bi = 0;
        for (int i = 0; i < obs.size() && i < ex_addr.size(); i++) begin
            ed = '0;
            mk = '0;
            for (int k = 0; k < ex_x[i]; k++) begin
                lane = big_endian ? (3 - int'(ex_addr[i][1:0]) - k) : k;
                lane = big_endian ? (3 - (ex_be[i][3] ? 0 : (ex_be[i][2] ? 1 : (ex_be[i][1] ? 2 : 3))) - k) : lane;
                lane = big_endian ? lane : ((ex_be[i][0] ? 0 : (ex_be[i][1] ? 1 : (ex_be[i][2] ? 2 : 3))) + k);
                ed[lane*8 +: 8] = eb[bi + k];
                mk[lane*8 +: 8] = 8'hFF;
            end
            bi += ex_x[i];
            chk($sformatf("%s_addr%0d", tag, i), 64'(obs[i].addr), 64'(ex_addr[i]));
            chk($sformatf("%s_be%0d", tag, i), 64'(obs[i].be), 64'(ex_be[i]));
            chk($sformatf("%s_data%0d", tag, i), 64'(obs[i].data & mk), 64'(ed));
        end
        chk({tag, "_fifo_left"}, 64'(fq.size()), 64'd0);
`ifdef GP_DMA_WR_ENG_STATS_EN
        chk({tag, "_wr_beats"}, 64'(wr_beats), 64'(ex_addr.size()));
`endif
        step();
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    int p0;
    int g0;

    initial begin
        repeat (3) step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("rst_req", 64'(bus_req), 64'd0);
        chk("rst_outs", {bus_addr, bus_wdata}, 64'd0);
        chk("rst_be", 64'(bus_be), 64'd0);
        rst = 1'b0;
        step();

        gnt_mode = 1;
        thr = 0;
        launch(32'h100, 8, 1'b0);
        finish_xfer("t1", 100);

        launch(32'h103, 6, 1'b0);
        finish_xfer("t2", 100);

        occ_cap = 0;
        launch(32'h101, 1, 1'b0);
        chk("t3_baddr", 64'(fifo_rd_baddress), 64'd1);
        chk("t3_xcnt", 64'(fifo_rd_xcnt), 64'd1);
        occ_cap = -1;
        finish_xfer("t3le", 100);
        launch(32'h101, 1, 1'b1);
        finish_xfer("t3be", 100);

        occ_cap = 2;
        p0 = pops;
        launch(32'h200, 4, 1'b0);
        repeat (5) step();
        chk("t4_nopop", 64'(pops - p0), 64'd0);
        chk("t4_noreq", 64'(bus_req), 64'd0);
        chk("t4_busy", 64'(busy), 64'd1);
        occ_cap = -1;
        step();
        chk("t4_rd_en", 64'(fifo_rd_en), 64'd1);
        step();
        chk("t4_req", 64'(bus_req), 64'd1);
        finish_xfer("t4", 100);

        p0 = pops;
        g0 = grants;
        launch(32'h300, 0, 1'b0);
        chk("t5_done", 64'(done), 64'd1);
        step();
        chk("t5_done_gone", 64'(done), 64'd0);
        chk("t5_idle", 64'(busy), 64'd0);
        chk("t5_cnt", {32'(pops - p0), 32'(grants - g0)}, 64'd0);
        chk("t5_ndone", 64'(dones - d0), 64'd1);

        gnt_mode = 0;
        launch(32'h400, 8, 1'b0);
        for (int i = 0; i < 50 && !bus_req; i++) step();
        chk("t6_req", 64'(bus_req), 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t6_req_drop", 64'(bus_req), 64'd0);
        chk("t6_idle", 64'(busy), 64'd0);
        step();
        chk("t6_nodone", 64'(dones - d0), 64'd0);
        chk("t6_nobeat", 64'(obs.size()), 64'd0);
        fq.delete();
        gnt_mode = 2;
        launch(32'h403, 9, 1'b1);
        finish_xfer("t6b", 200);

        launch(32'hFFFF_FFFE, 6, 1'b0);
        finish_xfer("wrap", 200);

        launch(32'h500, 12, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_req", {31'd0, bus_req, 31'd0, fifo_rd_en}, 64'd0);
        chk("arst_be", 64'(bus_be), 64'd0);
        step();
        rst = 1'b0;
        fq.delete();
        step();

        thr = 1;
        for (int t = 0; t < 20; t++) begin
            launch($urandom, int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)));
            finish_xfer($sformatf("rnd%0d", t), 2000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
